// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Receive-side readback of the multiplexed 7-segment display bus. The bus is
// resynchronized into clk. Each digit slot is qualified by stability, and its
// segment pattern is decoded back into a 4-bit digit. Scan order is checked,
// and a pulse is emitted when a complete four-digit frame has been seen.
//
// Parameters:
//   STABLE_CYCLES  identical synchronized samples needed before a capture (2..15)
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   seg[6:0]     segment bus, active-low, bit 6 = g ... bit 0 = a (async to clk)
//   an[3:0]      anode enables, active-low one-hot
//                (0 score ones, 1 score tens, 2 level ones, 3 level tens)
//   score1/score10/lvl1/lvl10  last decoded value per position
//   digit_valid  bit p set once position p has been captured since reset
//   frame_done   1-cycle pulse: all four positions captured in the current frame
//   seg_err      1-cycle pulse: stable segment pattern not a known digit
//   an_err       1-cycle pulse: stable anode pattern has more than one low bit
//   order_err    1-cycle pulse: capture position differs from the expected one
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [3:0] score1,
  output logic [3:0] score10,
  output logic [3:0] lvl1,
  output logic [3:0] lvl10,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       seg_err,
  output logic       an_err,
  output logic       order_err
);

  localparam logic [3:0] EVAL_CNT = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] SAT_CNT  = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {SETTLE, EVAL, HOLD} phase_t;

  logic [3:0]  r_an_m, r_an_s;
  logic [6:0]  r_seg_m, r_seg_s;
  logic [10:0] r_prev;
  logic [3:0]  r_stab_cnt;
  logic        r_taken;
  logic [3:0]  r_seen;
  logic [1:0]  r_exp;
  logic        r_exp_vld;
  logic        r_frame_done, r_seg_err, r_an_err, r_order_err;
  logic [3:0]  r_digit [4];
  logic        r_valid [4];

  logic [10:0] w_cur;
  logic        w_changed;
  phase_t      w_phase;
  logic        w_eval;
  logic [3:0]  w_an_eval;
  logic [6:0]  w_seg_eval;
  logic [3:0]  w_an_low;
  logic        w_blank, w_multi;
  logic        w_dec_ok;
  logic [3:0]  w_dec_val;
  logic [1:0]  w_pos;
  logic        w_capture;
  logic        w_order_bad;
  logic [3:0]  w_seen_or;
  logic        w_frame;

  assign w_cur     = {r_an_s, r_seg_s};
  assign w_changed = (w_cur != r_prev);

  // The evaluated value comes from prev. It holds the run of identical samples
  // that were counted, even if the bus moves on during the evaluation edge.
  assign w_an_eval  = r_prev[10:7];
  assign w_seg_eval = r_prev[6:0];

  always_comb begin
    w_phase = SETTLE;
    if (r_taken)
      w_phase = HOLD;
    else if (r_stab_cnt == EVAL_CNT)
      w_phase = EVAL;
  end
  assign w_eval = (w_phase == EVAL);

  // This expression is nonzero when more than one enable is low.
  assign w_an_low = ~w_an_eval;
  assign w_blank  = (w_an_eval == 4'b1111);
  assign w_multi  = |(w_an_low & (w_an_low - 4'd1));

  always_comb begin
    w_pos = 2'd0;
    case (w_an_eval)
      4'b1110: w_pos = 2'd0;
      4'b1101: w_pos = 2'd1;
      4'b1011: w_pos = 2'd2;
      4'b0111: w_pos = 2'd3;
      default: w_pos = 2'd0;
    endcase
  end

  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_val = 4'h0;
    case (w_seg_eval)
      7'b1000000: w_dec_val = 4'h0;
      7'b1111001: w_dec_val = 4'h1;
      7'b0100100: w_dec_val = 4'h2;
      7'b0110000: w_dec_val = 4'h3;
      7'b0011001: w_dec_val = 4'h4;
      7'b0010010: w_dec_val = 4'h5;
      7'b0000010: w_dec_val = 4'h6;
      7'b1111000: w_dec_val = 4'h7;
      7'b0000000: w_dec_val = 4'h8;
      7'b0010000: w_dec_val = 4'h9;
      7'b1111111: w_dec_val = 4'hF;  // blank digit, still a valid capture
      default:    w_dec_ok  = 1'b0;
    endcase
  end

  assign w_capture   = w_eval && !w_blank && !w_multi && w_dec_ok;
  assign w_order_bad = r_exp_vld && (w_pos != r_exp);
  // An out-of-order capture restarts the frame at this position.
  assign w_seen_or   = (w_order_bad ? 4'b0000 : r_seen) | (4'b0001 << w_pos);
  assign w_frame     = (w_seen_or == 4'b1111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_m       <= 4'hF;
      r_an_s       <= 4'hF;
      r_seg_m      <= 7'h7F;
      r_seg_s      <= 7'h7F;
      r_prev       <= 11'h7FF;
      r_stab_cnt   <= 4'd0;
      r_taken      <= 1'b1;
      r_seen       <= 4'b0000;
      r_exp        <= 2'd0;
      r_exp_vld    <= 1'b0;
      r_frame_done <= 1'b0;
      r_seg_err    <= 1'b0;
      r_an_err     <= 1'b0;
      r_order_err  <= 1'b0;
    end else begin
      r_an_m  <= an;
      r_an_s  <= r_an_m;
      r_seg_m <= seg;
      r_seg_s <= r_seg_m;
      r_prev  <= w_cur;

      if (w_changed) begin
        r_stab_cnt <= 4'd0;
        r_taken    <= 1'b0;
      end else begin
        if (r_stab_cnt != SAT_CNT)
          r_stab_cnt <= r_stab_cnt + 4'd1;
        if (w_eval)
          r_taken <= 1'b1;
      end

      r_an_err     <= w_eval && !w_blank && w_multi;
      r_seg_err    <= w_eval && !w_blank && !w_multi && !w_dec_ok;
      r_order_err  <= w_capture && w_order_bad;
      r_frame_done <= w_capture && w_frame;

      if (w_capture) begin
        r_exp     <= 2'(w_pos + 2'd1);
        r_exp_vld <= 1'b1;
        r_seen    <= w_frame ? 4'b0000 : w_seen_or;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pos
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_digit[gi] <= 4'h0;
          r_valid[gi] <= 1'b0;
        end else if (w_capture && (w_pos == 2'(gi))) begin
          r_digit[gi] <= w_dec_val;
          r_valid[gi] <= 1'b1;
        end
      end
      assign digit_valid[gi] = r_valid[gi];
    end
  endgenerate

  assign score1     = r_digit[0];
  assign score10    = r_digit[1];
  assign lvl1       = r_digit[2];
  assign lvl10      = r_digit[3];
  assign frame_done = r_frame_done;
  assign seg_err    = r_seg_err;
  assign an_err     = r_an_err;
  assign order_err  = r_order_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder (STABLE_CYCLES = 4).
// Each table row drives one bus slot and then checks the digit outputs.
// Expected pulses are queued when a row is driven and matched by a monitor.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;
  localparam int LAT    = 3 + STABLE;  // negedge drive -> negedge where result is visible

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] score1, score10, lvl1, lvl10, digit_valid;
  logic       frame_done, seg_err, an_err, order_err;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .score1(score1), .score10(score10), .lvl1(lvl1), .lvl10(lvl10),
    .digit_valid(digit_valid), .frame_done(frame_done), .seg_err(seg_err),
    .an_err(an_err), .order_err(order_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // pulses = {frame_done, seg_err, an_err, order_err}
  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] digits;  // {lvl10, lvl1, score10, score1}
    logic [3:0]  vld;
    logic [3:0]  pulses;
  } vec_t;

  typedef struct {
    logic [3:0] pulses;
    int         at;
  } ev_t;

  vec_t tbl[$];
  ev_t  evq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void add(input logic [3:0] a, input logic [6:0] s, input int h,
                              input logic [15:0] d, input logic [3:0] v, input logic [3:0] p);
    vec_t r;
    r.an = a; r.seg = s; r.hold = h; r.digits = d; r.vld = v; r.pulses = p;
    tbl.push_back(r);
  endfunction

  // Pulse monitor: every observed pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [3:0] p;
    ev_t e;
    p = {frame_done, seg_err, an_err, order_err};
    if (p != 4'b0000) begin
      if (evq.size() == 0) begin
        check("unexpected_pulse", 32'(p), 32'h0);
      end else begin
        e = evq.pop_front();
        check("pulse_kind", 32'(p), 32'(e.pulses));
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        $display("[TB] pulse %b at cycle %0d", p, cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge `hold` cycles later.
  task automatic apply_row(input int i);
    vec_t v;
    ev_t  e;
    v   = tbl[i];
    an  = v.an;
    seg = v.seg;
    if (v.pulses != 4'b0000) begin
      e.pulses = v.pulses;
      e.at     = cyc + LAT;
      evq.push_back(e);
    end
    repeat (v.hold) @(negedge clk);
    check($sformatf("row%0d_digits", i), 32'({lvl10, lvl1, score10, score1}), 32'(v.digits));
    check($sformatf("row%0d_valid", i), 32'(digit_valid), 32'(v.vld));
    if (v.pulses != 4'b0000)
      check($sformatf("row%0d_pulse_seen", i), 32'(evq.size()), 32'h0);
    $display("[TB] row %0d an=%b seg=%b digits=%h valid=%b", i, v.an, v.seg,
             {lvl10, lvl1, score10, score1}, digit_valid);
  endtask

  int r_rel;

  initial begin
    // Normal frame 7,3,5,0 (rows 0-3)
    add(4'b1110, 7'b1111000, 20, 16'h0007, 4'b0001, 4'b0000);
    add(4'b1101, 7'b0110000, 20, 16'h0037, 4'b0011, 4'b0000);
    add(4'b1011, 7'b0010010, 20, 16'h0537, 4'b0111, 4'b0000);
    add(4'b0111, 7'b1000000, 20, 16'h0537, 4'b1111, 4'b1000);
    // Glitch rejection: short "7", 3-clk "8", then "7" held (rows 4-6)
    add(4'b1110, 7'b1111000,  2, 16'h0537, 4'b1111, 4'b0000);
    add(4'b1110, 7'b0000000,  3, 16'h0537, 4'b1111, 4'b0000);
    add(4'b1110, 7'b1111000, 20, 16'h0537, 4'b1111, 4'b0000);
    // Bad segment pattern, then two enables low (rows 7-8)
    add(4'b1101, 7'b0101010, 20, 16'h0537, 4'b1111, 4'b0100);
    add(4'b1100, 7'b0101010, 20, 16'h0537, 4'b1111, 4'b0010);
    // Blank bus after reset (rows 9-10)
    add(4'b1111, 7'b0000010, 50, 16'h0000, 4'b0000, 4'b0000);
    add(4'b1111, 7'b1010101, 20, 16'h0000, 4'b0000, 4'b0000);
    // Order error: positions 0,2,3,0,1,2,3 (rows 11-17)
    add(4'b1110, 7'b1111001, 20, 16'h0001, 4'b0001, 4'b0000);
    add(4'b1011, 7'b0100100, 20, 16'h0201, 4'b0101, 4'b0001);
    add(4'b0111, 7'b0011001, 20, 16'h4201, 4'b1101, 4'b0000);
    add(4'b1110, 7'b0000010, 20, 16'h4206, 4'b1101, 4'b0000);
    add(4'b1101, 7'b0010000, 20, 16'h4296, 4'b1111, 4'b1000);
    add(4'b1011, 7'b0000000, 20, 16'h4896, 4'b1111, 4'b0000);
    add(4'b0111, 7'b1111111, 20, 16'hF896, 4'b1111, 4'b0000);

    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    check("reset_digits", 32'({lvl10, lvl1, score10, score1}), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_pulses", 32'({frame_done, seg_err, an_err, order_err}), 32'h0);
    rst = 1'b0;

    for (int i = 0; i <= 8; i++) apply_row(i);

    // Reset in the middle of a settle, then hold the bus.
    an  = 4'b1101;
    seg = 7'b0110000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_digits", 32'({lvl10, lvl1, score10, score1}), 32'h0);
    check("midrst_valid", 32'(digit_valid), 32'h0);
    repeat (3) @(negedge clk);
    check("midrst_held_valid", 32'(digit_valid), 32'h0);
    rst   = 1'b0;
    r_rel = cyc;
    repeat (LAT - 1) @(negedge clk);
    check("midrst_before_capture", 32'({digit_valid, score10}), 32'h00);
    @(negedge clk);
    check("midrst_capture_cycle", 32'(cyc - r_rel), 32'(LAT));
    check("midrst_capture", 32'({digit_valid, score10}), 32'h23);
    $display("[TB] reset-release capture: score10=%h valid=%b", score10, digit_valid);
    repeat (10) @(negedge clk);

    // Clean reset before the blank-bus and order-error sequences.
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'b0000010;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 9; i < tbl.size(); i++) apply_row(i);

    repeat (5) @(negedge clk);
    check("pending_events", 32'(evq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
